// File: rtl/pango_rx_tlp_adapter_pkg.sv
// rtl/pango_rx_tlp_adapter_pkg.sv - shared types and constants for the Pango RX TLP adapter
//   Beat-entry struct carried through the skid buffer, beat geometry, and TUSER bit indices.
package pango_rx_tlp_adapter_pkg;

    localparam int C_DW_PER_BEAT = 4;
    localparam int C_DATA_W      = C_DW_PER_BEAT * 32;
    localparam int C_OFF_W       = $clog2(C_DW_PER_BEAT);

    localparam int TUSER_BAR_LSB = 0;
    localparam int TUSER_BAR_MSB = 5;
    localparam int TUSER_ERR     = 6;

    typedef struct packed {
        logic [C_DATA_W-1:0] data;
        logic                start_flag;
        logic                end_flag;
        logic [C_OFF_W-1:0]  end_off;
        logic [5:0]          bar;
    } rx_beat_t;

    // Index of the highest set keep bit; 0 when no bit is set.
    function automatic logic [C_OFF_W-1:0] keep_hi_idx(input logic [C_DW_PER_BEAT-1:0] keep);
        logic [C_OFF_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < C_DW_PER_BEAT; i++) begin
            if (keep[i]) idx = C_OFF_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/pango_rx_skid_buf.sv
// rtl/pango_rx_skid_buf.sv - 2-entry valid/ready skid buffer with registered input ready
//   clk, resetn          : clock, synchronous active-low reset
//   s_tdata/tvalid/tready: upstream side; s_tready is registered
//   m_tdata/tvalid/tready: downstream side, FIFO order
module pango_rx_skid_buf #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic [W-1:0] s_tdata,
    input  logic         s_tvalid,
    output logic         s_tready,
    output logic [W-1:0] m_tdata,
    output logic         m_tvalid,
    input  logic         m_tready
);

    logic [W-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic [1:0]   count;
    logic [1:0]   count_nxt;
    logic         push;
    logic         pop;

    assign push      = s_tvalid & s_tready;
    assign pop       = m_tvalid & m_tready;
    assign count_nxt = count + 2'(push) - 2'(pop);

    assign m_tvalid = (count != 2'd0);
    assign m_tdata  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!resetn) begin
            mem[0]   <= '0;
            mem[1]   <= '0;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            count    <= 2'd0;
            s_tready <= 1'b0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= s_tdata;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            count    <= count_nxt;
            // Ready looks at next-cycle occupancy so a full buffer never sees a push.
            s_tready <= (count_nxt != 2'd2);
        end
    end

endmodule

// File: rtl/pango_rx_tlp_adapter.sv
// rtl/pango_rx_tlp_adapter.sv - Pango PCIe AXI-S RX to RIFFA RX_TLP adapter
//   USER_CLK, USER_RST_N        : clock, synchronous active-low reset
//   AXIS_RX_*                   : Pango IP master stream in (TUSER [5:0] BAR, [6] error)
//   RX_TLP, RX_TLP_VALID/READY  : RIFFA beat stream out
//   RX_TLP_START/END_FLAG/OFFSET: per-beat framing derived from TLAST/TKEEP
//   RX_TLP_BAR_DECODE           : BAR hit latched at SOP
//   RX_PROTO_ERR                : one-cycle pulse on malformed TKEEP at accept
//   RX_DROP_COUNT               : dropped TLPs (PANGO_RX_DISCARD_ERR_EN), else 0
//   Optional feature macro: PANGO_RX_DISCARD_ERR_EN drops TLPs whose SOP carries TUSER[6].
import pango_rx_tlp_adapter_pkg::*;

module pango_rx_tlp_adapter #(
    parameter int C_PCI_DATA_WIDTH = 128,
    parameter int C_KEEP_W         = 4,
    parameter int C_DROP_CNT_W     = 16
) (
    input  logic                        USER_CLK,
    input  logic                        USER_RST_N,
    input  logic [C_PCI_DATA_WIDTH-1:0] AXIS_RX_TDATA,
    input  logic [C_KEEP_W-1:0]         AXIS_RX_TKEEP,
    input  logic                        AXIS_RX_TLAST,
    input  logic                        AXIS_RX_TVALID,
    output logic                        AXIS_RX_TREADY,
    input  logic [7:0]                  AXIS_RX_TUSER,
    output logic [C_PCI_DATA_WIDTH-1:0] RX_TLP,
    output logic                        RX_TLP_VALID,
    input  logic                        RX_TLP_READY,
    output logic                        RX_TLP_START_FLAG,
    output logic [1:0]                  RX_TLP_START_OFFSET,
    output logic                        RX_TLP_END_FLAG,
    output logic [1:0]                  RX_TLP_END_OFFSET,
    output logic [5:0]                  RX_TLP_BAR_DECODE,
    output logic                        RX_PROTO_ERR,
    output logic [C_DROP_CNT_W-1:0]     RX_DROP_COUNT
);

    rx_beat_t   in_beat;
    rx_beat_t   out_beat;
    logic       sop_pending;
    logic [5:0] bar_q;
    logic       in_fire;
    logic       buf_tvalid;
    logic       keep_ok;
    logic       proto_err_d;
    logic       drop_beat;

    assign in_fire = AXIS_RX_TVALID & AXIS_RX_TREADY;

    assign keep_ok = (AXIS_RX_TKEEP == 4'b0001) || (AXIS_RX_TKEEP == 4'b0011) ||
                     (AXIS_RX_TKEEP == 4'b0111) || (AXIS_RX_TKEEP == 4'b1111);
    assign proto_err_d = !keep_ok || (!AXIS_RX_TLAST && (AXIS_RX_TKEEP != 4'b1111));

    always_comb begin
        in_beat            = '0;
        in_beat.data       = AXIS_RX_TDATA;
        in_beat.start_flag = sop_pending;
        in_beat.end_flag   = AXIS_RX_TLAST;
        // Malformed keep still uses the highest-set-bit rule so the beat is forwarded.
        in_beat.end_off    = AXIS_RX_TLAST ? keep_hi_idx(AXIS_RX_TKEEP) : '0;
        in_beat.bar        = sop_pending ? AXIS_RX_TUSER[TUSER_BAR_MSB:TUSER_BAR_LSB] : bar_q;
    end

    always_ff @(posedge USER_CLK) begin
        if (!USER_RST_N) begin
            sop_pending  <= 1'b1;
            bar_q        <= '0;
            RX_PROTO_ERR <= 1'b0;
        end else begin
            RX_PROTO_ERR <= in_fire & proto_err_d;
            if (in_fire) begin
                sop_pending <= AXIS_RX_TLAST;
                bar_q       <= in_beat.bar;
            end
        end
    end

`ifdef PANGO_RX_DISCARD_ERR_EN
    logic                    drop_q;
    logic [C_DROP_CNT_W-1:0] drop_cnt;
    logic                    unused_tuser;

    // The error bit only matters on the SOP beat; later beats inherit the decision.
    assign drop_beat = sop_pending ? AXIS_RX_TUSER[TUSER_ERR] : drop_q;

    always_ff @(posedge USER_CLK) begin
        if (!USER_RST_N) begin
            drop_q   <= 1'b0;
            drop_cnt <= '0;
        end else if (in_fire) begin
            drop_q <= drop_beat;
            if (drop_beat && AXIS_RX_TLAST && (drop_cnt != '1))
                drop_cnt <= drop_cnt + {{(C_DROP_CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign RX_DROP_COUNT = drop_cnt;
    assign unused_tuser  = AXIS_RX_TUSER[7];
`else
    logic unused_tuser;

    assign drop_beat     = 1'b0;
    assign RX_DROP_COUNT = '0;
    assign unused_tuser  = ^AXIS_RX_TUSER[7:6];
`endif

    // Dropped beats are still handshaken upstream; they just never enter the buffer.
    assign buf_tvalid = AXIS_RX_TVALID & ~drop_beat;

    pango_rx_skid_buf #(
        .W($bits(rx_beat_t))
    ) u_skid (
        .clk      (USER_CLK),
        .resetn   (USER_RST_N),
        .s_tdata  (in_beat),
        .s_tvalid (buf_tvalid),
        .s_tready (AXIS_RX_TREADY),
        .m_tdata  (out_beat),
        .m_tvalid (RX_TLP_VALID),
        .m_tready (RX_TLP_READY)
    );

    assign RX_TLP              = out_beat.data;
    assign RX_TLP_START_FLAG   = out_beat.start_flag;
    assign RX_TLP_START_OFFSET = 2'd0;
    assign RX_TLP_END_FLAG     = out_beat.end_flag;
    assign RX_TLP_END_OFFSET   = out_beat.end_off;
    assign RX_TLP_BAR_DECODE   = out_beat.bar;

endmodule
